// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift sequencer (SLL/SRL/SRA), STEP bits per cycle.
// Accepts one request at a time on a valid/ready handshake, iterates a small
// shifter until the full amount has been applied, then holds the result in
// DONE until the consumer takes it. busy flags the hazard unit while active.
// Optional feature: define SHIFT_SEQ_ROTATE_EN to make shtype 2'b11 a rotate
// right; otherwise shtype 2'b11 is a passthrough completing in one edge.
module shift_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [1:0]               shtype,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [WIDTH-1:0]         y,
    output logic                     busy
);

    localparam int REM_W = $clog2(WIDTH);
    localparam logic [REM_W-1:0] STEP_C = REM_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ALT = 2'b11  // rotate right or passthrough, depending on build
    } shtype_e;

    state_e            state_q, state_d;
    shtype_e           type_q,  type_d;
    logic [WIDTH-1:0]  acc_q,   acc_d;
    logic [REM_W-1:0]  rem_q,   rem_d;

    logic [REM_W-1:0]  step;
    logic [WIDTH-1:0]  shifted;
    logic              accept;
    logic              passthru;

    assign ready_out = (state_q == ST_IDLE) && !flush;
    assign valid_out = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign y         = acc_q;
    assign accept    = valid_in && ready_out;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign passthru = 1'b0;
`else
    assign passthru = (shtype == 2'b11);
`endif

    // Per-cycle shift amount: whatever remains, capped at STEP.
    assign step = (rem_q < STEP_C) ? rem_q : STEP_C;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [REM_W:0] WIDTH_C = (REM_W+1)'(WIDTH);
    logic [REM_W:0] rot_amt;
    assign rot_amt = WIDTH_C - {1'b0, step};
`endif

    // Small STEP-wide shifter applied to the accumulator once per SHIFT cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        shifted = acc_q;
        unique case (type_q)
            SH_SLL: shifted = acc_q << step;
            SH_SRL: shifted = acc_q >> step;
            SH_SRA: shifted = $unsigned($signed(acc_q) >>> step);
`ifdef SHIFT_SEQ_ROTATE_EN
            SH_ALT: shifted = (acc_q >> step) | (acc_q << rot_amt);
`else
            SH_ALT: shifted = acc_q;
`endif
            default: shifted = acc_q;
        endcase
    end

    // Next-state logic: accept in IDLE, iterate in SHIFT, hand off in DONE; flush overrides all.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        type_d  = type_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d  = a;
                    rem_d  = shamt;
                    type_d = shtype_e'(shtype);
                    state_d = ((shamt == '0) || passthru) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = shifted;
                rem_d = rem_q - step;  // step <= rem_q, cannot underflow
                if (rem_q == step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            type_q  <= SH_SLL;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: table-driven check of shift_seq (WIDTH=32, STEP=4) with a
// result/latency scoreboard, plus hand-written stall, flush and reset sequences.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  shtype;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] y;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb_y[$];
    int          sb_lat[$];

    typedef struct {
        logic [1:0]  t;
        logic [31:0] av;
        logic [4:0]  sh;
        logic [31:0] ey;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    shift_seq #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a         (a),
        .shamt     (shamt),
        .shtype    (shtype),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .y         (y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one request, push expectations, then wait (bounded) for the result.
    task automatic run_op(input logic [1:0] t, input logic [31:0] av, input logic [4:0] sh,
                          input logic [31:0] ey, input int el, input string nm);
        int edges;
        logic [31:0] exp_y;
        int exp_lat;
        @(negedge clk);
        check({nm, " ready_out idle"}, 32'(ready_out), 32'd1);
        valid_in = 1'b1;
        a        = av;
        shamt    = sh;
        shtype   = t;
        @(posedge clk);
        sb_y.push_back(ey);
        sb_lat.push_back(el);
        #1;
        valid_in = 1'b0;
        edges = 1;
        while (!valid_out && edges < 20) begin
            check({nm, " busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            edges++;
        end
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        check({nm, " latency"}, 32'(edges), 32'(exp_lat));
        check({nm, " y"}, y, exp_y);
        check({nm, " busy done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({nm, " valid drop"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        a = '0; shamt = '0; shtype = '0;

        vecs.push_back('{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9});
        vecs.push_back('{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 2});
        vecs.push_back('{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 2});
        vecs.push_back('{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1});
        vecs.push_back('{2'b10, 32'h8765_4321, 5'd13, 32'hFFFC_3B2A, 5});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 9});
        vecs.push_back('{2'b00, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500, 3});
        vecs.push_back('{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 9});
        vecs.push_back('{2'b00, 32'h0000_0003, 5'd1,  32'h0000_0006, 2});
`ifdef SHIFT_SEQ_ROTATE_EN
        vecs.push_back('{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F, 2});
        vecs.push_back('{2'b11, 32'h0000_0001, 5'd31, 32'h0000_0002, 9});
`else
        vecs.push_back('{2'b11, 32'h0000_00F1, 5'd4,  32'h0000_00F1, 1});
        vecs.push_back('{2'b11, 32'h1234_5678, 5'd31, 32'h1234_5678, 1});
`endif

        // Reset state while reset is held.
        #12;
        check("reset ready_out", 32'(ready_out), 32'd1);
        check("reset valid_out", 32'(valid_out), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset y",         y,              32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].t, vecs[i].av, vecs[i].sh, vecs[i].ey, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Consumer stall in DONE: result and valid held, no new accept.
        @(negedge clk);
        ready_in = 1'b0;
        valid_in = 1'b1; a = 32'hDEAD_BEEF; shamt = 5'd0; shtype = 2'b01;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("stall valid first", 32'(valid_out), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("stall valid", 32'(valid_out), 32'd1);
            check("stall y", y, 32'hDEAD_BEEF);
            check("stall ready_out", 32'(ready_out), 32'd0);
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        check("stall release valid", 32'(valid_out), 32'd0);
        check("stall release ready", 32'(ready_out), 32'd1);

        // Flush on the second SHIFT cycle with a competing request.
        @(negedge clk);
        valid_in = 1'b1; a = 32'h0000_0001; shamt = 5'd20; shtype = 2'b00;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1; valid_in = 1'b1; a = 32'h0000_0055; shamt = 5'd0;
        #1;
        check("flush ready_out low", 32'(ready_out), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; valid_in = 1'b0;
        #1;
        check("flush busy", 32'(busy), 32'd0);
        check("flush valid", 32'(valid_out), 32'd0);
        check("flush ready_out", 32'(ready_out), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("flush no result", 32'(valid_out), 32'd0);
        end
        run_op(2'b00, 32'h0000_0003, 5'd1, 32'h0000_0006, 2, "post-flush");

        // Asynchronous reset pulse in the middle of a long shift.
        @(negedge clk);
        valid_in = 1'b1; a = 32'h0000_0001; shamt = 5'd31; shtype = 2'b00;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async rst valid", 32'(valid_out), 32'd0);
        check("async rst busy",  32'(busy),      32'd0);
        check("async rst ready", 32'(ready_out), 32'd1);
        check("async rst y",     y,              32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("post-rst no result", 32'(valid_out), 32'd0);
        end
        run_op(2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 2, "post-reset");

        check("scoreboard empty", 32'(sb_y.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
